// File: rtl/spi_defs_pkg.sv
// Shared SPI definitions: FSM state encodings used by the shift engine
// and any SPI sequencing FSM built on top of it.
package spi_defs;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } spiState_t;

   // Bits needed to count from 0 up to and including width.
   function automatic int bitCountWidth(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/shift_bit_counter.sv
// Bit counter for the shift engine: clear, increment and the
// terminal-count compare that marks the last bit of a word.
module shift_bit_counter
   import spi_defs::*;
#(
   parameter int WIDTH = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic increment,
   output logic terminal
);

   localparam int CW = bitCountWidth(WIDTH);

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (increment) begin
         count <= count + CW'(1);
      end
   end

   // High while the next counted strobe is the final one of the word.
   assign terminal = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/spi_shift_engine.sv
// SPI shift register engine: parallel load or receive-only start, then
// one bit per counted strobe, with a one-cycle pulse when the word completes.
//
// state | meaning
// IDLE  | waiting for parallelLoad or start; strobes ignored
// SHIFT | transfer active; each strobe shifts one bit and counts it
module spi_shift_engine
   import spi_defs::*;
#(
   parameter int WIDTH     = 8,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             peripheralClkEdge,
   input  logic             parallelLoad,
   input  logic             start,
   input  logic [WIDTH-1:0] parallelDataIn,
   input  logic             serialDataIn,
   output logic [WIDTH-1:0] parallelDataOut,
   output logic             serialDataOut,
   output logic             busy,
   output logic             wordDone
);

   spiState_t        stateQ, stateD;
   logic [WIDTH-1:0] shiftReg;
   logic [WIDTH-1:0] shiftedValue;
   logic             wordDoneD;
   logic             loadReg;
   logic             shiftEn;
   logic             cntClear;
   logic             cntInc;
   logic             cntTerminal;

   shift_bit_counter #(
      .WIDTH(WIDTH)
   ) bitCounter (
      .clk      (clk),
      .reset    (reset),
      .clear    (cntClear),
      .increment(cntInc),
      .terminal (cntTerminal)
   );

   always_comb begin
      stateD    = stateQ;
      loadReg   = 1'b0;
      shiftEn   = 1'b0;
      cntClear  = 1'b0;
      cntInc    = 1'b0;
      wordDoneD = 1'b0;
      case (stateQ)
         IDLE: begin
            if (parallelLoad) begin
               loadReg  = 1'b1;
               cntClear = 1'b1;
               stateD   = SHIFT;
            end else if (start) begin
               cntClear = 1'b1;
               stateD   = SHIFT;
            end
         end
         SHIFT: begin
            // A load restarts the word and swallows any coincident strobe.
            if (parallelLoad) begin
               loadReg  = 1'b1;
               cntClear = 1'b1;
            end else if (peripheralClkEdge) begin
               shiftEn = 1'b1;
               cntInc  = 1'b1;
               if (cntTerminal) begin
                  stateD    = IDLE;
                  wordDoneD = 1'b1;
               end
            end
         end
         default: stateD = IDLE;
      endcase
   end

   always_comb begin
      shiftedValue = shiftReg;
      if (MSB_FIRST != 0) begin
         shiftedValue = {shiftReg[WIDTH-2:0], serialDataIn};
      end else begin
         shiftedValue = {serialDataIn, shiftReg[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stateQ   <= IDLE;
         shiftReg <= '0;
         wordDone <= 1'b0;
      end else begin
         stateQ   <= stateD;
         wordDone <= wordDoneD;
         if (loadReg) begin
            shiftReg <= parallelDataIn;
         end else if (shiftEn) begin
            shiftReg <= shiftedValue;
         end
      end
   end

   assign parallelDataOut = shiftReg;
   assign serialDataOut   = (MSB_FIRST != 0) ? shiftReg[WIDTH-1] : shiftReg[0];
   assign busy            = (stateQ == SHIFT);

endmodule

// File: tb/tb_spi_shift_engine.sv
// Scoreboard bench for spi_shift_engine: three instances (8-bit MSB first,
// 8-bit LSB first, 12-bit MSB first) driven with directed vectors.
module tb_spi_shift_engine;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  strobe, load, start, sin;
   logic [7:0]  din0, din1;
   logic [11:0] din2;
   logic [7:0]  pdo0, pdo1;
   logic [11:0] pdo2;
   logic [2:0]  sdo, busy, wd;

   always #5 clk = ~clk;

   spi_shift_engine #(.WIDTH(8), .MSB_FIRST(1)) dut0 (
      .clk(clk), .reset(reset), .peripheralClkEdge(strobe[0]), .parallelLoad(load[0]),
      .start(start[0]), .parallelDataIn(din0), .serialDataIn(sin[0]),
      .parallelDataOut(pdo0), .serialDataOut(sdo[0]), .busy(busy[0]), .wordDone(wd[0]));

   spi_shift_engine #(.WIDTH(8), .MSB_FIRST(0)) dut1 (
      .clk(clk), .reset(reset), .peripheralClkEdge(strobe[1]), .parallelLoad(load[1]),
      .start(start[1]), .parallelDataIn(din1), .serialDataIn(sin[1]),
      .parallelDataOut(pdo1), .serialDataOut(sdo[1]), .busy(busy[1]), .wordDone(wd[1]));

   spi_shift_engine #(.WIDTH(12), .MSB_FIRST(1)) dut2 (
      .clk(clk), .reset(reset), .peripheralClkEdge(strobe[2]), .parallelLoad(load[2]),
      .start(start[2]), .parallelDataIn(din2), .serialDataIn(sin[2]),
      .parallelDataOut(pdo2), .serialDataOut(sdo[2]), .busy(busy[2]), .wordDone(wd[2]));

   typedef struct {
      int          dut;
      string       name;
      logic [31:0] pdo;
      logic        sdo;
      logic        busy;
      logic        wd;
      int          cyc;
   } exp_t;

   exp_t sbQ[$];
   int   cycleCnt    = 0;
   int   vectors     = 0;
   int   miscompares = 0;

   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   // Monitor: pops every expectation due this cycle and compares mid-cycle.
   always @(negedge clk) begin
      exp_t        e;
      logic [31:0] aPdo;
      logic        aSdo, aBusy, aWd;
      bit          bad;
      while (sbQ.size() > 0 && sbQ[0].cyc <= cycleCnt) begin
         e = sbQ.pop_front();
         case (e.dut)
            0:       begin aPdo = {24'h0, pdo0}; aSdo = sdo[0]; aBusy = busy[0]; aWd = wd[0]; end
            1:       begin aPdo = {24'h0, pdo1}; aSdo = sdo[1]; aBusy = busy[1]; aWd = wd[1]; end
            default: begin aPdo = {20'h0, pdo2}; aSdo = sdo[2]; aBusy = busy[2]; aWd = wd[2]; end
         endcase
         vectors++;
         bad = 1'b0;
         if (e.cyc != cycleCnt) bad = 1'b1;
         if (aPdo !== e.pdo)    bad = 1'b1;
         if (aSdo !== e.sdo)    bad = 1'b1;
         if (aBusy !== e.busy)  bad = 1'b1;
         if (aWd !== e.wd)      bad = 1'b1;
         if (bad) begin
            miscompares++;
            $display("FAIL %s dut%0d cyc%0d: got pdo=%h sdo=%b busy=%b wd=%b, want pdo=%h sdo=%b busy=%b wd=%b (due cyc%0d)",
                     e.name, e.dut, cycleCnt, aPdo, aSdo, aBusy, aWd, e.pdo, e.sdo, e.busy, e.wd, e.cyc);
         end
      end
   end

   initial begin
      repeat (5000) @(posedge clk);
      $display("FAIL watchdog: run exceeded cycle budget, vectors=%0d miscompares=%0d", vectors, miscompares);
      $fatal(1, "watchdog");
   end

   task automatic tick(input int d, input bit ld, input bit st, input bit sb, input bit si,
                       input logic [31:0] din, input bit rst);
      reset     = rst;
      load[d]   = ld;
      start[d]  = st;
      strobe[d] = sb;
      sin[d]    = si;
      case (d)
         0:       din0 = din[7:0];
         1:       din1 = din[7:0];
         default: din2 = din[11:0];
      endcase
      @(posedge clk);
      #1;
      reset  = 1'b0;
      load   = '0;
      start  = '0;
      strobe = '0;
   endtask

   task automatic push(input int d, input string n, input logic [31:0] p,
                       input logic s, input logic b, input logic w);
      exp_t e;
      e.dut  = d;
      e.name = n;
      e.pdo  = p;
      e.sdo  = s;
      e.busy = b;
      e.wd   = w;
      e.cyc  = cycleCnt;
      sbQ.push_back(e);
   endtask

   logic [7:0] aExp [8];
   logic [7:0] bExp [8];
   logic [7:0] dExp [8];
   logic [7:0] rExp [8];

   initial begin
      aExp = '{8'h99, 8'h33, 8'h67, 8'hCF, 8'h9F, 8'h3F, 8'h7F, 8'hFF};
      bExp = '{8'hE6, 8'h73, 8'h39, 8'h1C, 8'h0E, 8'h07, 8'h03, 8'h01};
      dExp = '{8'h4A, 8'h94, 8'h28, 8'h50, 8'hA0, 8'h40, 8'h80, 8'h00};
      rExp = '{8'h1E, 8'h3C, 8'h78, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
      reset = 1'b1; strobe = '0; load = '0; start = '0; sin = '0;
      din0 = '0; din1 = '0; din2 = '0;

      // Reset state with busy inputs asserted: reset must win.
      load = 3'b111; strobe = 3'b111; start = 3'b111;
      @(posedge clk); #1;
      load = '0; strobe = '0; start = '0;
      tick(0, 0, 0, 0, 0, 0, 1);
      push(0, "reset0", 32'h0, 0, 0, 0);
      push(1, "reset1", 32'h0, 0, 0, 0);
      push(2, "reset2", 32'h0, 0, 0, 0);

      // 8-bit MSB first: load CC, shift in ones.
      tick(0, 1, 0, 0, 0, 32'hCC, 0);
      push(0, "A_load", 32'hCC, 1, 1, 0);
      for (int i = 0; i < 8; i++) begin
         tick(0, 0, 0, 1, 1, 0, 0);
         push(0, $sformatf("A_shift%0d", i + 1), {24'h0, aExp[i]}, aExp[i][7], i != 7, i == 7);
         if (i == 2) begin
            tick(0, 0, 0, 0, 1, 0, 0);
            push(0, "A_hold", 32'h67, 0, 1, 0);
         end
      end
      tick(0, 0, 0, 0, 0, 0, 0);
      push(0, "A_after", 32'hFF, 1, 0, 0);

      // 8-bit LSB first: load CC, one 1 then zeros.
      tick(1, 1, 0, 0, 0, 32'hCC, 0);
      push(1, "B_load", 32'hCC, 0, 1, 0);
      for (int i = 0; i < 8; i++) begin
         tick(1, 0, 0, 1, i == 0, 0, 0);
         push(1, $sformatf("B_shift%0d", i + 1), {24'h0, bExp[i]}, bExp[i][0], i != 7, i == 7);
      end

      // Strobes while idle are ignored.
      for (int i = 0; i < 5; i++) begin
         tick(0, 0, 0, 1, 1, 0, 0);
         push(0, $sformatf("C_idle%0d", i + 1), 32'hFF, 1, 0, 0);
      end

      // Load with a coincident strobe: strobe discarded, 8 more strobes needed.
      tick(0, 1, 0, 1, 1, 32'hA5, 0);
      push(0, "D_loadStrobe", 32'hA5, 1, 1, 0);
      for (int i = 0; i < 8; i++) begin
         tick(0, 0, 0, 1, 0, 0, 0);
         push(0, $sformatf("D_shift%0d", i + 1), {24'h0, dExp[i]}, dExp[i][7], i != 7, i == 7);
      end
      // Back-to-back load in the wordDone cycle, start ignored, reload mid-word.
      tick(0, 1, 0, 0, 0, 32'h3C, 0);
      push(0, "D_b2bLoad", 32'h3C, 0, 1, 0);
      tick(0, 0, 0, 1, 1, 0, 0);
      push(0, "D_b2bShift1", 32'h79, 0, 1, 0);
      tick(0, 0, 0, 1, 1, 0, 0);
      push(0, "D_b2bShift2", 32'hF3, 1, 1, 0);
      tick(0, 0, 1, 0, 0, 0, 0);
      push(0, "D_startIgnored", 32'hF3, 1, 1, 0);
      tick(0, 1, 0, 1, 1, 32'h0F, 0);
      push(0, "D_reload", 32'h0F, 0, 1, 0);
      for (int i = 0; i < 8; i++) begin
         tick(0, 0, 0, 1, 0, 0, 0);
         push(0, $sformatf("D_reShift%0d", i + 1), {24'h0, rExp[i]}, rExp[i][7], i != 7, i == 7);
      end

      // Reset mid-transfer aborts without wordDone.
      tick(0, 1, 0, 0, 0, 32'h5A, 0);
      push(0, "E_load", 32'h5A, 0, 1, 0);
      tick(0, 0, 0, 1, 1, 0, 0);
      push(0, "E_shift1", 32'hB5, 1, 1, 0);
      tick(0, 0, 0, 1, 1, 0, 0);
      push(0, "E_shift2", 32'h6B, 0, 1, 0);
      tick(0, 0, 0, 1, 1, 0, 0);
      push(0, "E_shift3", 32'hD7, 1, 1, 0);
      tick(0, 0, 0, 1, 1, 0, 1);
      push(0, "E_reset", 32'h00, 0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         tick(0, 0, 0, 1, 1, 0, 0);
         push(0, $sformatf("E_quiet%0d", i + 1), 32'h00, 0, 0, 0);
      end

      // 12-bit receive-only transfer with alternating input.
      tick(2, 0, 1, 0, 0, 0, 0);
      push(2, "F_start", 32'h000, 0, 1, 0);
      for (int i = 0; i < 12; i++) begin
         tick(2, 0, 0, 1, (i % 2) == 0, 0, 0);
         if (i == 10) push(2, "F_shift11", 32'h555, 0, 1, 0);
         if (i == 11) push(2, "F_shift12", 32'hAAA, 1, 0, 1);
      end
      tick(2, 0, 0, 0, 0, 0, 0);
      push(2, "F_after", 32'hAAA, 1, 0, 0);

      repeat (3) @(posedge clk);
      while (sbQ.size() > 0) begin
         exp_t e;
         e = sbQ.pop_front();
         vectors++;
         miscompares++;
         $display("FAIL %s dut%0d: expectation never checked (due cyc%0d)", e.name, e.dut, e.cyc);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      if (miscompares != 0) begin
         $display("FAIL: %0d miscompares", miscompares);
      end else begin
         $display("PASS");
      end
      $finish;
   end

endmodule
